// File: rtl/i2c_txn_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the I2C transaction sequencer:
//   - FSM state encoding (IDLE/START/WAIT/RESP)
//   - response status codes returned to the host
//   - command record layout stored in the command FIFO (addr + wdata)
// -----------------------------------------------------------------------------
package i2c_seq_pkg;

  // One queued command: {addr, wdata}
  localparam int CMD_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [1:0] RSP_OK  = 2'b00;
  localparam logic [1:0] RSP_ERR = 2'b01;
  localparam logic [1:0] RSP_TMO = 2'b10;

  typedef struct packed {
    logic [7:0] addr;   // {7-bit slave addr, R/W}, bit0=1 means read
    logic [7:0] wdata;  // write byte, don't-care for reads
  } cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// -----------------------------------------------------------------------------
// i2c_cmd_fifo
// DEPTH x CMD_W synchronous FIFO holding host commands for the sequencer.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// Head entry is presented combinationally on o_rdata.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (flushes pointers)
//   i_push        write i_wdata (ignored when full)
//   i_wdata       command record to store
//   i_pop         advance read pointer (ignored when empty)
//   o_rdata       current head entry
//   o_full        DEPTH entries held
//   o_empty       no entries held
// -----------------------------------------------------------------------------
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [CMD_W-1:0] i_wdata,
  input  logic             i_pop,
  output logic [CMD_W-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  // Same slot index but opposite wrap bit: writer is a full lap ahead.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; entries are only read once the pointers say valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/i2c_txn_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_txn_sequencer
// Upstream feeder for i2c_master. Queues single-byte transactions from a host,
// issues each as a one-cycle start pulse, waits for the master's done/err
// (rising edges) or a timeout, and returns one response per command.
//
// Optional feature macro: I2C_SEQ_RETRY_EN
//   defined     : an err in WAIT re-issues the same command up to MAX_RETRY
//                 times before reporting status 01.
//   not defined : every err reports status 01 immediately.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   host command handshake (ready = FIFO not full)
//   cmd_addr          {7-bit slave addr, R/W}, bit0=1 read
//   cmd_wdata         write byte
//   rsp_valid/ready   response handshake, fields held until accepted
//   rsp_addr          cmd_addr of the completed command
//   rsp_rdata         read byte (0x00 for writes and failures)
//   rsp_status        00 ok, 01 err, 10 timeout
//   busy              FSM not idle or commands still queued
//   m_start           one-cycle start pulse to the master
//   m_addr            address to the master, held from START through WAIT
//   m_num_bytes       always 1
//   m_data_o/m_data_oe write byte and its bus enable (writes in START/WAIT)
//   m_data_i          master data bus readback
//   m_done, m_err     master completion / failure levels
// -----------------------------------------------------------------------------
module i2c_txn_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 1023,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_addr,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_status,
  output logic       busy,
  output logic       m_start,
  output logic [7:0] m_addr,
  output logic [5:0] m_num_bytes,
  output logic [7:0] m_data_o,
  output logic       m_data_oe,
  input  logic [7:0] m_data_i,
  input  logic       m_done,
  input  logic       m_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  logic [1:0]       r_state;
  cmd_t             r_cmd;
  logic [TW-1:0]    r_timer;
  logic             r_done_q;
  logic             r_err_q;
  logic [7:0]       r_rsp_addr;
  logic [7:0]       r_rsp_rdata;
  logic [1:0]       r_rsp_status;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [CMD_W-1:0] w_fifo_rdata;
  cmd_t             w_head;
  logic             w_evt_done;
  logic             w_evt_err;
  logic             w_can_retry;
  logic [TW-1:0]    w_timer_nxt;
  logic             w_active;

  assign w_push = cmd_valid && !w_full;
  assign w_pop  = (r_state == ST_IDLE) && !w_empty;
  assign w_head = cmd_t'(w_fifo_rdata);

  i2c_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_push),
    .i_wdata ({cmd_addr, cmd_wdata}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Master signals are levels; only their rising edges mean anything.
  assign w_evt_done  = m_done && !r_done_q;
  assign w_evt_err   = m_err && !r_err_q;
  assign w_timer_nxt = r_timer + TW'(1);
  assign w_active    = (r_state == ST_START) || (r_state == ST_WAIT);

`ifdef I2C_SEQ_RETRY_EN
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RW-1:0] r_retry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retry <= '0;
    end else if (r_state == ST_IDLE) begin
      r_retry <= '0;
    end else if ((r_state == ST_WAIT) && w_evt_err && w_can_retry) begin
      r_retry <= r_retry + RW'(1);
    end
  end

  assign w_can_retry = (r_retry < RW'(MAX_RETRY));
`else
  // Retries compiled out; MAX_RETRY is kept only so both builds share a port/param list.
  assign w_can_retry = 1'b0 && (MAX_RETRY >= 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd        <= '0;
      r_timer      <= '0;
      r_done_q     <= 1'b0;
      r_err_q      <= 1'b0;
      r_rsp_addr   <= '0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= RSP_OK;
    end else begin
      r_done_q <= m_done;
      r_err_q  <= m_err;
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_cmd   <= w_head;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_timer <= w_timer_nxt;
          // Priority: err over done over timeout.
          if (w_evt_err) begin
            if (w_can_retry) begin
              r_state <= ST_START;
            end else begin
              r_rsp_addr   <= r_cmd.addr;
              r_rsp_rdata  <= 8'h00;
              r_rsp_status <= RSP_ERR;
              r_state      <= ST_RESP;
            end
          end else if (w_evt_done) begin
            r_rsp_addr   <= r_cmd.addr;
            r_rsp_rdata  <= r_cmd.addr[0] ? m_data_i : 8'h00;
            r_rsp_status <= RSP_OK;
            r_state      <= ST_RESP;
          end else if (w_timer_nxt == TMO_LIMIT) begin
            // Lands in RESP exactly TIMEOUT cycles after WAIT was entered.
            r_rsp_addr   <= r_cmd.addr;
            r_rsp_rdata  <= 8'h00;
            r_rsp_status <= RSP_TMO;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready   = !w_full;
  assign busy        = (r_state != ST_IDLE) || !w_empty;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_addr    = r_rsp_addr;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_status  = r_rsp_status;
  assign m_start     = (r_state == ST_START);
  assign m_addr      = r_cmd.addr;
  assign m_num_bytes = 6'd1;
  assign m_data_o    = r_cmd.wdata;
  assign m_data_oe   = w_active && !r_cmd.addr[0];

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
module tb_i2c_txn_sequencer;

  localparam int DEPTH = 4;
  localparam int TMO   = 40;
  localparam int MR    = 2;
`ifdef I2C_SEQ_RETRY_EN
  localparam bit RETRY = 1'b1;
`else
  localparam bit RETRY = 1'b0;
`endif

  // Master behaviour per command
  localparam int K_DONE = 0;  // done on every attempt
  localparam int K_ERR  = 1;  // err on every attempt
  localparam int K_ERR1 = 2;  // err on first attempt, done afterwards
  localparam int K_TMO  = 3;  // silent
  localparam int K_BOTH = 4;  // err and done rise together on every attempt

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    int         kind;
    logic [7:0] rd;
    logic [7:0] e_rdata;
    logic [1:0] e_status;
    int         e_starts;
  } txn_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_addr;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic       busy;
  logic       m_start;
  logic [7:0] m_addr;
  logic [5:0] m_num_bytes;
  logic [7:0] m_data_o;
  logic       m_data_oe;
  logic [7:0] m_data_i;
  logic       m_done;
  logic       m_err;

  txn_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   starts_seen = 0;
  int   start_cyc = 0;
  int   acc_cyc = 0;
  bit   hold = 1'b0;

  i2c_txn_sequencer #(
    .DEPTH     (DEPTH),
    .TIMEOUT   (TMO),
    .MAX_RETRY (MR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_addr    (rsp_addr),
    .rsp_rdata   (rsp_rdata),
    .rsp_status  (rsp_status),
    .busy        (busy),
    .m_start     (m_start),
    .m_addr      (m_addr),
    .m_num_bytes (m_num_bytes),
    .m_data_o    (m_data_o),
    .m_data_oe   (m_data_oe),
    .m_data_i    (m_data_i),
    .m_done      (m_done),
    .m_err       (m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: outcome of a command from its R/W bit and the master behaviour.
  function automatic txn_t model(input logic [7:0] a, input logic [7:0] wd,
                                 input int kind, input logic [7:0] rd);
    txn_t t;
    t.addr = a; t.wdata = wd; t.kind = kind; t.rd = rd;
    t.e_rdata = 8'h00; t.e_status = 2'b01; t.e_starts = 1;
    case (kind)
      K_DONE: begin
        t.e_status = 2'b00;
        t.e_rdata  = a[0] ? rd : 8'h00;
      end
      K_ERR, K_BOTH: t.e_starts = RETRY ? MR + 1 : 1;
      K_ERR1: begin
        if (RETRY) begin
          t.e_status = 2'b00;
          t.e_rdata  = a[0] ? rd : 8'h00;
          t.e_starts = 2;
        end
      end
      K_TMO: t.e_status = 2'b10;
      default: ;
    endcase
    return t;
  endfunction

  // Master model: reacts to each start pulse according to the head command.
  initial begin : master
    int delay;
    int attempt;
    bit pending;
    delay = 0; attempt = 0; pending = 1'b0;
    m_done = 1'b0; m_err = 1'b0; m_data_i = 8'h00;
    forever begin
      @(negedge clk);
      m_done = 1'b0;
      m_err  = 1'b0;
      if (rst) begin
        pending = 1'b0;
        starts_seen = 0;
      end else if (m_start) begin
        chk("start_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("m_addr", int'(m_addr), int'(exp_q[0].addr));
          chk("m_data_oe_start", int'(m_data_oe), int'(!exp_q[0].addr[0]));
          if (!exp_q[0].addr[0]) chk("m_data_o", int'(m_data_o), int'(exp_q[0].wdata));
          attempt = starts_seen;
          starts_seen++;
          start_cyc = cyc;
          delay = int'($urandom_range(1, 5));
          pending = 1'b1;
        end
      end else if (pending && exp_q.size() != 0) begin
        chk("m_data_oe_wait", int'(m_data_oe), int'(!exp_q[0].addr[0]));
        delay--;
        if (delay == 0) begin
          pending = 1'b0;
          case (exp_q[0].kind)
            K_DONE: begin m_data_i = exp_q[0].rd; m_done = 1'b1; end
            K_ERR:  begin m_data_i = 8'($urandom); m_err = 1'b1; end
            K_BOTH: begin m_data_i = exp_q[0].rd; m_err = 1'b1; m_done = 1'b1; end
            K_ERR1: begin
              m_data_i = exp_q[0].rd;
              if (attempt == 0) m_err = 1'b1;
              else m_done = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Monitor: compares each presented response with the scoreboard head.
  initial begin : monitor
    bit   seen;
    txn_t t;
    seen = 1'b0;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
        rsp_ready = 1'b0;
      end else if (rsp_valid) begin
        if (!seen) begin
          seen = 1'b1;
          if (exp_q.size() == 0) begin
            chk("rsp_unexpected", int'(rsp_valid), 0);
          end else begin
            t = exp_q.pop_front();
            chk("rsp_addr", int'(rsp_addr), int'(t.addr));
            chk("rsp_rdata", int'(rsp_rdata), int'(t.e_rdata));
            chk("rsp_status", int'(rsp_status), int'(t.e_status));
            chk("start_count", starts_seen, t.e_starts);
            if (t.kind == K_TMO) chk("tmo_latency", cyc - start_cyc, TMO + 1);
            starts_seen = 0;
          end
        end else begin
          chk("rsp_hold_addr", int'(rsp_addr), int'(t.addr));
          chk("rsp_hold_status", int'(rsp_status), int'(t.e_status));
        end
        rsp_ready = hold ? 1'b0 : ($urandom_range(0, 2) != 0);
      end else begin
        seen = 1'b0;
        rsp_ready = 1'b0;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] wd,
                      input int kind, input logic [7:0] rd);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = wd;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("cmd_accept_timeout", int'(cmd_ready), 1);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(a, wd, kind, rd));
    acc_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", int'(busy || exp_q.size() != 0), 0);
  endtask

  initial begin : main
    int kind;
    logic [7:0] a;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_m_start", int'(m_start), 0);
    chk("rst_m_data_oe", int'(m_data_oe), 0);
    chk("rst_m_addr", int'(m_addr), 0);
    chk("rst_rsp_fields", int'({rsp_addr, rsp_rdata, rsp_status}), 0);
    chk("m_num_bytes", int'(m_num_bytes), 1);
    rst = 1'b0;
    @(negedge clk);

    // T1 read
    send(8'hBD, 8'h00, K_DONE, 8'h6D);
    wait_idle(200);
    chk("t1_latency", start_cyc - acc_cyc, 2);
    // T2 write
    send(8'hBC, 8'h6A, K_DONE, 8'h33);
    wait_idle(200);
    // T4 err variants, same-cycle err+done
    send(8'hA1, 8'h00, K_ERR, 8'h11);
    send(8'h52, 8'hC3, K_ERR1, 8'h22);
    send(8'h37, 8'h00, K_ERR1, 8'h9E);
    send(8'h36, 8'h5B, K_BOTH, 8'h44);
    wait_idle(600);
    // T5 timeout, read and write
    send(8'h91, 8'h00, K_TMO, 8'h00);
    send(8'h90, 8'h5A, K_TMO, 8'h00);
    wait_idle(400);

    // T3 backpressure: first command is popped, next four fill the FIFO
    hold = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(8'h20 + i), 8'(8'hA0 + i), K_DONE, 8'(8'h70 + i));
    chk("t3_full_ready", int'(cmd_ready), 0);
    chk("t3_busy", int'(busy), 1);
    cmd_valid = 1'b1; cmd_addr = 8'hEE; cmd_wdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_blocked", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    hold = 1'b0;
    wait_idle(800);

    // Randomised traffic
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind <= 4) kind = K_DONE;
      else if (kind == 5) kind = K_ERR;
      else if (kind == 6) kind = K_ERR1;
      else if (kind == 7) kind = K_BOTH;
      else if (kind == 8) kind = K_TMO;
      else kind = K_DONE;
      a = 8'($urandom);
      send(a, 8'($urandom), kind, 8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_idle(6000);
    chk("queue_drained", exp_q.size(), 0);

    // T6 reset mid-WAIT with two commands queued
    send(8'h44, 8'hEE, K_TMO, 8'h00);
    send(8'h45, 8'h00, K_TMO, 8'h00);
    send(8'h47, 8'h00, K_TMO, 8'h00);
    repeat (3) @(negedge clk);
    chk("t6_pre_oe", int'(m_data_oe), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rsp_valid", int'(rsp_valid), 0);
    chk("t6_busy", int'(busy), 0);
    chk("t6_cmd_ready", int'(cmd_ready), 1);
    chk("t6_m_start", int'(m_start), 0);
    chk("t6_m_data_oe", int'(m_data_oe), 0);
    exp_q.delete();
    rst = 1'b0;
    repeat (2 * TMO) @(negedge clk);
    chk("t6_no_restart", starts_seen, 0);
    chk("t6_idle_after", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
